// File: rtl/axil_debug_ram_if.sv
// AXI4-Lite bus bundle for axil_debug_ram: AW, W, B, AR and R channels.
// The slave modport is the memory side; master is the requester side.
interface axil_debug_ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_debug_ram.sv
// AXI4-Lite slave word memory with a side debug port for preload/inspection.
// Reads have one cycle latency; writes commit one edge after both AW and W are held.
module axil_debug_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  axil_debug_ram_if.slave       s_axil,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
  input  logic [ADDR_WIDTH-1:0] debug_wr_addr,
  input  logic [DATA_WIDTH-1:0] debug_wr_data,
  input  logic                  debug_wr_en
);
  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return {1'b0, idx} < DEPTH_W;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Holds every ready low until the first edge after reset is released.
  logic ready_en_q;

  always_ff @(posedge clk) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic                  arready, rvalid;

  assign ar_idx = s_axil.araddr >> BYTE_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = ready_en_q;
        if (s_axil.arvalid && ready_en_q) begin
          // Sampled before this edge's writes land, so a colliding write is not seen.
          rdata_d   = in_range(ar_idx) ? mem_q[ar_idx[MEM_AW-1:0]] : '0;
          rresp_d   = in_range(ar_idx) ? RESP_OKAY : RESP_DECERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axil.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axil.arready = arready;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  // ---------------- write channel ----------------
  logic                  aw_have_q, aw_have_d;
  logic                  w_have_q, w_have_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready, wready, commit;
  logic [DATA_WIDTH-1:0] merged_word;

  assign awready = ready_en_q && !aw_have_q && !bvalid_q;
  assign wready  = ready_en_q && !w_have_q && !bvalid_q;
  assign commit  = aw_have_q && w_have_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (s_axil.awvalid && awready) begin
      aw_have_d = 1'b1;
      aw_idx_d  = s_axil.awaddr >> BYTE_SHIFT;
    end
    if (s_axil.wvalid && wready) begin
      w_have_d = 1'b1;
      wdata_d  = s_axil.wdata;
      wstrb_d  = s_axil.wstrb;
    end
    if (commit) begin
      aw_have_d = 1'b0;
      w_have_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = in_range(aw_idx_q) ? RESP_OKAY : RESP_DECERR;
    end
    if (bvalid_q && s_axil.bready) bvalid_d = 1'b0;
  end

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = wstrb_q[gi] ? wdata_q[gi*8 +: 8]
                                                  : mem_q[aw_idx_q[MEM_AW-1:0]][gi*8 +: 8];
    end
  endgenerate

  // Debug write is issued last so it wins a same-word collision with the AXI commit.
  always_ff @(posedge clk) begin
    if (commit && !rst && in_range(aw_idx_q))
      mem_q[aw_idx_q[MEM_AW-1:0]] <= merged_word;
    if (debug_wr_en && in_range(debug_wr_addr))
      mem_q[debug_wr_addr[MEM_AW-1:0]] <= debug_wr_data;
  end

  assign debug_data = in_range(debug_addr) ? mem_q[debug_addr[MEM_AW-1:0]] : '0;

  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot};
endmodule

// File: tb/tb_axil_debug_ram.sv
// Directed bench for axil_debug_ram: reset, reads, strobed writes, ordering,
// back-pressure, out-of-range accesses, collisions and mid-transaction reset.
module tb_axil_debug_ram;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] debug_addr, debug_wr_addr;
  logic [31:0] debug_data, debug_wr_data;
  logic        debug_wr_en;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axil_debug_ram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axil_debug_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axil        (bus.slave),
    .debug_addr    (debug_addr),
    .debug_data    (debug_data),
    .debug_wr_addr (debug_wr_addr),
    .debug_wr_data (debug_wr_data),
    .debug_wr_en   (debug_wr_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_wr(input logic [15:0] idx, input logic [31:0] data);
    debug_wr_addr = idx;
    debug_wr_data = data;
    debug_wr_en   = 1'b1;
    tick();
    debug_wr_en   = 1'b0;
  endtask

  task automatic dbg_chk(input string tag, input logic [15:0] idx, input logic [31:0] exp);
    debug_addr = idx;
    #1;
    chk(tag, debug_data, exp);
  endtask

  task automatic ar_send(input logic [15:0] addr);
    chk("arready_before_ar", bus.arready, 1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic r_accept();
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic b_accept();
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic aw_w_send(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    debug_addr = '0; debug_wr_addr = '0; debug_wr_data = '0; debug_wr_en = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_arready", bus.arready, 0);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bresp", bus.bresp, 0);
    rst = 1'b0;
    #1;
    chk("arready_at_release", bus.arready, 0);
    tick();
    chk("arready_after_release", bus.arready, 1);
    chk("awready_after_release", bus.awready, 1);
    chk("wready_after_release", bus.wready, 1);
    $display("reset sequence done");

    // 1: debug preload then AXI read
    dbg_wr(16'd5, 32'hDEADBEEF);
    dbg_chk("t1_debug_rd", 16'd5, 32'hDEADBEEF);
    ar_send(16'h0014);
    chk("t1_rvalid", bus.rvalid, 1);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t1_rresp", bus.rresp, 0);
    chk("t1_arready_busy", bus.arready, 0);
    r_accept();
    chk("t1_rvalid_clear", bus.rvalid, 0);
    $display("txn read idx5 -> %08h", 32'hDEADBEEF);

    // 2: AW+W same cycle with partial strobe
    dbg_wr(16'd8, 32'hFFFFFFFF);
    aw_w_send(16'h0020, 32'h11223344, 4'b0101);
    chk("t2_awready_held", bus.awready, 0);
    chk("t2_wready_held", bus.wready, 0);
    chk("t2_bvalid_early", bus.bvalid, 0);
    tick();
    chk("t2_bvalid", bus.bvalid, 1);
    chk("t2_bresp", bus.bresp, 0);
    chk("t2_awready_during_b", bus.awready, 0);
    dbg_chk("t2_merged", 16'd8, 32'hFF22FF44);
    b_accept();
    chk("t2_bvalid_clear", bus.bvalid, 0);
    chk("t2_awready_back", bus.awready, 1);
    $display("txn write idx8 strb=0101 -> %08h", 32'hFF22FF44);

    // 3: W three cycles before AW
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("t3_wready_after_w", bus.wready, 0);
    chk("t3_awready_open", bus.awready, 1);
    tick();
    chk("t3_bvalid_wait1", bus.bvalid, 0);
    tick();
    chk("t3_bvalid_wait2", bus.bvalid, 0);
    bus.awaddr = 16'h000C; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t3_bvalid_at_aw", bus.bvalid, 0);
    tick();
    chk("t3_bvalid", bus.bvalid, 1);
    chk("t3_bresp", bus.bresp, 0);
    dbg_chk("t3_data", 16'd3, 32'hCAFEF00D);
    b_accept();
    $display("txn write W-before-AW idx3 -> %08h", 32'hCAFEF00D);

    // 4: read collision with debug write, then rready held low
    dbg_wr(16'd10, 32'h0A0A0A0A);
    debug_wr_addr = 16'd10; debug_wr_data = 32'h00000055; debug_wr_en = 1'b1;
    ar_send(16'h0028);
    debug_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_rvalid_hold", bus.rvalid, 1);
      chk("t4_rdata_old", bus.rdata, 32'h0A0A0A0A);
      chk("t4_arready_low", bus.arready, 0);
      tick();
    end
    dbg_chk("t4_debug_new", 16'd10, 32'h00000055);
    r_accept();
    chk("t4_rvalid_clear", bus.rvalid, 0);
    chk("t4_arready_back", bus.arready, 1);
    $display("txn read idx10 held 4 cycles -> %08h", 32'h0A0A0A0A);

    // 5: out of range
    dbg_wr(16'd0, 32'h0BADF00D);
    ar_send(16'h0400);
    chk("t5_rresp", bus.rresp, 2'b11);
    chk("t5_rdata", bus.rdata, 0);
    r_accept();
    aw_w_send(16'h0400, 32'h12345678, 4'hF);
    tick();
    chk("t5_bvalid", bus.bvalid, 1);
    chk("t5_bresp", bus.bresp, 2'b11);
    b_accept();
    dbg_chk("t5_idx0_kept", 16'd0, 32'h0BADF00D);
    dbg_chk("t5_debug_oor", 16'd256, 32'h0);
    dbg_wr(16'd256, 32'hFFFF0000);
    dbg_chk("t5_debug_wr_ignored", 16'd0, 32'h0BADF00D);
    $display("txn out-of-range idx256 -> DECERR");

    // 7: debug write beats AXI write on same word
    aw_w_send(16'h0024, 32'h11111111, 4'hF);
    debug_wr_addr = 16'd9; debug_wr_data = 32'h22222222; debug_wr_en = 1'b1;
    tick();
    debug_wr_en = 1'b0;
    chk("t7_bvalid", bus.bvalid, 1);
    dbg_chk("t7_debug_wins", 16'd9, 32'h22222222);
    b_accept();
    $display("txn write collision idx9 -> %08h", 32'h22222222);

    // 6: reset with bvalid and rvalid pending
    ar_send(16'h0014);
    aw_w_send(16'h0050, 32'h600DCAFE, 4'hF);
    tick();
    chk("t6_bvalid_pending", bus.bvalid, 1);
    chk("t6_rvalid_pending", bus.rvalid, 1);
    rst = 1'b1;
    tick();
    chk("t6_bvalid_dropped", bus.bvalid, 0);
    chk("t6_rvalid_dropped", bus.rvalid, 0);
    chk("t6_arready_in_rst", bus.arready, 0);
    rst = 1'b0;
    tick();
    chk("t6_arready_back", bus.arready, 1);
    dbg_chk("t6_mem_idx20", 16'd20, 32'h600DCAFE);
    dbg_chk("t6_mem_idx5", 16'd5, 32'hDEADBEEF);
    ar_send(16'h0050);
    chk("t6_axi_readback", bus.rdata, 32'h600DCAFE);
    r_accept();
    $display("txn reset mid-transaction, idx20 -> %08h", 32'h600DCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
